compat_fir_40mhz: RTL and testbench
===================================

# compat_fir_40mhz

Front end of the 40 MHz compatibility trigger path. The block takes the three raw 120 MHz PMT ADC streams and applies a symmetric low-pass FIR that emulates the UB anti-alias response. It decimates the result by 3 and generates the shared ENABLE40 phase. Its filtered, held outputs and ENABLE40 drive the ToTd, ToT and threshold compatibility triggers directly.

## Interface
- Parameters:
- ADC_WIDTH, 12, width of ADC samples in and out
- NTAPS, 21, FIR length; must be odd; coefficients are symmetric
- COEF_WIDTH, 12, signed coefficient width
- COEF_SHIFT, 10, final right shift; coefficients sum to 2^COEF_SHIFT for unity DC gain
- Ports:
- CLK120  in  1  120 MHz ADC clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- SYNC  in  1  single-cycle pulse that realigns the decimation phase
- ADC0/ADC1/ADC2  in  ADC_WIDTH  raw unsigned samples, one per CLK120
- FILT0/FILT1/FILT2  out  ADC_WIDTH  filtered samples at the full 120 MHz rate (debug/monitor)
- ADC0_40/ADC1_40/ADC2_40  out  ADC_WIDTH  decimated filtered samples, held for 3 cycles
- ENABLE40  out  2  decimation phase counter, sequence 0,1,2,0,...

## Operation
- Reset (RESET_N low, asynchronous):
  - every output clears to 0, as do all delay-line, pipeline and phase registers.
  - Outputs stay 0 until the pipeline refills: the first valid FILTx appears 6 cycles after the first sample following reset release.
- Per channel, an NTAPS-deep shift register of input samples advances every CLK120.
- Symmetric pre-add:
  - pairs tap k and tap NTAPS-1-k for k = 0..(NTAPS-3)/2; the centre tap is used alone.
  - Sums are unsigned, ADC_WIDTH+1 bits.
- Multiply each pre-add sum by the signed coefficient, giving (NTAPS+1)/2 products.
- Accumulate through a two-stage registered adder tree. The accumulator is signed and ADC_WIDTH+COEF_WIDTH+5 bits wide, which is sufficient for no overflow.
- Rounding and saturation:
  - add 2^(COEF_SHIFT-1), then shift arithmetically right by COEF_SHIFT;
  - clamp the result to 0 if negative and to 2^ADC_WIDTH-1 if above;
  - register the clamped value to FILTx.
- Phase counter ENABLE40:
  - increments mod 3 every cycle;
  - if SYNC is high, ENABLE40 becomes 0 on the next edge regardless of its current value; SYNC takes priority over increment;
  - SYNC asserted on consecutive cycles holds ENABLE40 at 0.
- Decimation: ADCx_40 loads FILTx on the edge that ends a cycle with ENABLE40 == 2, and holds otherwise.
  - Consequence: a new value is visible throughout the following phases 0, 1 and 2, so a consumer registering ENABLE40 once and sampling at its local phase 0 sees a stable value.
  - When SYNC truncates a phase, the load occurs only if ENABLE40 == 2 in that cycle. A truncated 40 MHz period therefore produces no update, and the previous value is held.
- The three channels share coefficients and phase and are bit-identical in behaviour.

## Timing
- Pipeline stages, in cycles after sample x[n] is presented:
  1. input register;
  2. pre-add;
  3. multiply;
  4. first adder-tree stage;
  5. second adder-tree stage;
  6. round/saturate into FILTx.
- FILTx at cycle n+6 reflects the window ending at x[n], so latency is 6 cycles.
- ADCx_40 lags FILTx by 1 to 3 cycles depending on phase. Decimation takes no additional pipeline stages.
- Throughput: one sample per cycle per channel, with no stalls and no back-pressure.
- ENABLE40 is registered and its first value after reset release is 0.

## Structure
- Shared package compat_pkg holds:
  - the coefficient array (localparam, (NTAPS+1)/2 entries, centre last) with COEF_SHIFT;
  - the ENABLE40 phase constants, in the same file as the existing compatibility-trigger widths in sde_trigger_defs.vh.
- One sub-module, compat_fir_chan. It contains one channel's delay line, pre-add, multiply, tree and saturation, and is instantiated three times.
- The top level contains only the phase counter, the decimation registers and the instances.

## Test plan
- DC input 1000 on all channels from reset → FILTx = 1000 from cycle 6 + NTAPS onward; ADCx_40 = 1000 and constant.
- Impulse: a single sample of 1024 on ADC0 over a zero baseline → FILT0 reproduces the coefficient sequence, round(1024·c_k/2^COEF_SHIFT), for k = 0..20 starting at cycle 6 after the impulse; FILT1 and FILT2 stay 0.
- Saturation:
  - a step from 0 to 4095 whose overshoot exceeds full scale → FILTx clamps at 4095 and never wraps;
  - a negative-lobe undershoot after a 4095→0 step → FILTx clamps at 0.
- Phase: free-running ENABLE40 → pattern 0,1,2; a SYNC pulse while ENABLE40 == 1 → next value 0, no ADCx_40 update for the truncated period, then normal updates resume.
- Decimation alignment: a ramp input incrementing by 1 per cycle → ADCx_40 changes only on edges after ENABLE40 == 2, and successive values differ by 3.
- Reset mid-stream: RESET_N pulled low asynchronously during active data → all outputs 0 immediately (without waiting for a clock edge); after release, ENABLE40 restarts at 0 and DC output recovers after 6 + NTAPS cycles.

Source files
------------

// File: rtl/compat_pkg.sv
// compat_pkg: shared constants, coefficient table and phase helper for the
// 40 MHz compatibility-trigger front end (FIR + decimation by 3).
package compat_pkg;

    localparam int CMP_ADC_WIDTH  = 12;
    localparam int CMP_NTAPS      = 21;
    localparam int CMP_COEF_WIDTH = 12;
    localparam int CMP_COEF_SHIFT = 10;
    localparam int CMP_NCOEF      = (CMP_NTAPS + 1) / 2;

    // Half of the symmetric low-pass response, outer tap first, centre tap last.
    // Hamming-windowed sinc with cutoff at fs/6, so the 40 MHz output is not
    // aliased. Mirrored sum is exactly 2^CMP_COEF_SHIFT (unity DC gain).
    localparam logic signed [CMP_COEF_WIDTH-1:0] CMP_COEF [CMP_NCOEF] = '{
        -12'sd2,  12'sd0,   12'sd6,   12'sd11,  12'sd0,  -12'sd31,
        -12'sd48, 12'sd0,   12'sd129, 12'sd276, 12'sd342
    };

    // ENABLE40 phase values; the decimation registers load in PH_LOAD.
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2
    } phase_e;

    localparam phase_e PH_LOAD = PH_2;

    // Next ENABLE40 phase: SYNC forces phase 0, otherwise count modulo 3.
    function automatic phase_e phase_next(input phase_e cur, input logic sync);
        phase_e nxt;
        if (sync) begin
            nxt = PH_0;
        end else begin
            case (cur)
                PH_0:    nxt = PH_1;
                PH_1:    nxt = PH_2;
                PH_2:    nxt = PH_0;
                default: nxt = PH_0;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/compat_fir_chan.sv
// compat_fir_chan: one channel of the symmetric low-pass FIR.
// Stages: input delay line, pre-add, multiply, two adder-tree stages and
// round/saturate, giving 6 cycles from sample to output.
module compat_fir_chan
    import compat_pkg::*;
#(
    parameter int ADC_WIDTH  = CMP_ADC_WIDTH,
    parameter int NTAPS      = CMP_NTAPS,
    parameter int COEF_WIDTH = CMP_COEF_WIDTH,
    parameter int COEF_SHIFT = CMP_COEF_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [ADC_WIDTH-1:0] i_sample,
    output logic [ADC_WIDTH-1:0] o_filt
);

    localparam int NPROD  = (NTAPS + 1) / 2;
    localparam int NPAIR  = NPROD - 1;
    localparam int SUM_W  = ADC_WIDTH + 1;
    localparam int PROD_W = SUM_W + 1 + COEF_WIDTH;
    localparam int ACC_W  = ADC_WIDTH + COEF_WIDTH + 5;
    localparam int GRP    = 4;
    localparam int NGRP   = (NPROD + GRP - 1) / GRP;

    localparam logic signed [ACC_W-1:0] ROUND_BIAS =
        {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-ADC_WIDTH){1'b0}}, {ADC_WIDTH{1'b1}}};

    logic        [ADC_WIDTH-1:0] r_taps [NTAPS];
    logic        [SUM_W-1:0]     r_sum  [NPROD];
    logic signed [PROD_W-1:0]    w_opa  [NPROD];
    logic signed [PROD_W-1:0]    w_opc  [NPROD];
    logic signed [PROD_W-1:0]    r_prod [NPROD];
    logic signed [ACC_W-1:0]     w_part [NGRP];
    logic signed [ACC_W-1:0]     r_part [NGRP];
    logic signed [ACC_W-1:0]     w_total;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     w_rounded;
    logic signed [ACC_W-1:0]     w_shifted;
    logic        [ADC_WIDTH-1:0] w_sat;
    logic        [ADC_WIDTH-1:0] r_filt;

    // Delay line: tap 0 is the input register, older samples move outward.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) r_taps[k] <= '0;
        end else begin
            r_taps[0] <= i_sample;
            for (int k = 1; k < NTAPS; k++) r_taps[k] <= r_taps[k-1];
        end
    end

    // Pre-add mirrored taps (unsigned, one bit wider); centre tap passes alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NPROD; k++) r_sum[k] <= '0;
        end else begin
            for (int k = 0; k < NPAIR; k++) begin
                r_sum[k] <= {1'b0, r_taps[k]} + {1'b0, r_taps[NTAPS-1-k]};
            end
            r_sum[NPAIR] <= {1'b0, r_taps[NPAIR]};
        end
    end

    // Multiplier operands sign-extended to the full product width.
    for (genvar g = 0; g < NPROD; g++) begin : g_mul_ops
        assign w_opa[g] = PROD_W'($signed({1'b0, r_sum[g]}));
        assign w_opc[g] = PROD_W'(CMP_COEF[g]);
    end

    // Multiply each pre-add sum by its signed coefficient.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NPROD; k++) r_prod[k] <= '0;
        end else begin
            for (int k = 0; k < NPROD; k++) r_prod[k] <= w_opa[k] * w_opc[k];
        end
    end

    // First tree stage: sum products in groups of GRP.
    always_comb begin
        for (int g = 0; g < NGRP; g++) w_part[g] = '0;
        for (int k = 0; k < NPROD; k++) begin
            w_part[k/GRP] = w_part[k/GRP] + ACC_W'(r_prod[k]);
        end
    end

    // Register the group partial sums.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int g = 0; g < NGRP; g++) r_part[g] <= '0;
        end else begin
            for (int g = 0; g < NGRP; g++) r_part[g] <= w_part[g];
        end
    end

    // Second tree stage: combine the partial sums.
    always_comb begin
        w_total = '0;
        for (int g = 0; g < NGRP; g++) w_total = w_total + r_part[g];
    end

    // Register the full accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_total;
        end
    end

    assign w_rounded = r_acc + ROUND_BIAS;
    assign w_shifted = w_rounded >>> COEF_SHIFT;

    // Clamp to the unsigned ADC range so overshoot and undershoot never wrap.
    always_comb begin
        w_sat = '0;
        if (w_shifted[ACC_W-1]) begin
            w_sat = '0;
        end else if (w_shifted > SAT_MAX) begin
            w_sat = '1;
        end else begin
            w_sat = w_shifted[ADC_WIDTH-1:0];
        end
    end

    // Output register for the filtered sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt <= '0;
        end else begin
            r_filt <= w_sat;
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/compat_fir_40mhz.sv
// compat_fir_40mhz: three FIR channels, the shared ENABLE40 phase counter and
// the decimation registers that hold one filtered sample per 40 MHz period.
module compat_fir_40mhz
    import compat_pkg::*;
#(
    parameter int ADC_WIDTH  = CMP_ADC_WIDTH,
    parameter int NTAPS      = CMP_NTAPS,
    parameter int COEF_WIDTH = CMP_COEF_WIDTH,
    parameter int COEF_SHIFT = CMP_COEF_SHIFT
) (
    input  logic                 CLK120,
    input  logic                 RESET_N,
    input  logic                 SYNC,
    input  logic [ADC_WIDTH-1:0] ADC0,
    input  logic [ADC_WIDTH-1:0] ADC1,
    input  logic [ADC_WIDTH-1:0] ADC2,
    output logic [ADC_WIDTH-1:0] FILT0,
    output logic [ADC_WIDTH-1:0] FILT1,
    output logic [ADC_WIDTH-1:0] FILT2,
    output logic [ADC_WIDTH-1:0] ADC0_40,
    output logic [ADC_WIDTH-1:0] ADC1_40,
    output logic [ADC_WIDTH-1:0] ADC2_40,
    output logic [1:0]           ENABLE40
);

    logic [ADC_WIDTH-1:0] w_adc    [3];
    logic [ADC_WIDTH-1:0] w_filt   [3];
    logic [ADC_WIDTH-1:0] r_adc40  [3];
    phase_e               r_phase;
    phase_e               w_phase_next;

    assign w_adc[0] = ADC0;
    assign w_adc[1] = ADC1;
    assign w_adc[2] = ADC2;

    for (genvar c = 0; c < 3; c++) begin : g_chan
        compat_fir_chan #(
            .ADC_WIDTH  (ADC_WIDTH),
            .NTAPS      (NTAPS),
            .COEF_WIDTH (COEF_WIDTH),
            .COEF_SHIFT (COEF_SHIFT)
        ) u_chan (
            .i_clk    (CLK120),
            .i_rst_n  (RESET_N),
            .i_sample (w_adc[c]),
            .o_filt   (w_filt[c])
        );
    end

    // Phase state register.
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_phase <= PH_0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next phase: SYNC realigns to 0, otherwise advance modulo 3.
    always_comb begin
        w_phase_next = PH_0;
        w_phase_next = phase_next(r_phase, SYNC);
    end

    // Decimation: capture the filtered sample only at the end of phase 2,
    // so a period truncated by SYNC leaves the previous value held.
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < 3; c++) r_adc40[c] <= '0;
        end else if (r_phase == PH_LOAD) begin
            for (int c = 0; c < 3; c++) r_adc40[c] <= w_filt[c];
        end else begin
            for (int c = 0; c < 3; c++) r_adc40[c] <= r_adc40[c];
        end
    end

    assign FILT0    = w_filt[0];
    assign FILT1    = w_filt[1];
    assign FILT2    = w_filt[2];
    assign ADC0_40  = r_adc40[0];
    assign ADC1_40  = r_adc40[1];
    assign ADC2_40  = r_adc40[2];
    assign ENABLE40 = r_phase;

endmodule

// File: tb/tb_compat_fir_40mhz.sv
// tb_compat_fir_40mhz: directed stimulus with a scoreboard. Each stimulus
// step pushes the expected outputs (from a direct-form reference FIR and a
// phase model) plus hand-computed directed expectations; a monitor on the
// falling edge pops and compares whenever an expectation falls due.
module tb_compat_fir_40mhz;

    logic        CLK120  = 1'b0;
    logic        RESET_N = 1'b1;
    logic        SYNC    = 1'b0;
    logic [11:0] ADC0 = 12'd0, ADC1 = 12'd0, ADC2 = 12'd0;
    logic [11:0] FILT0, FILT1, FILT2;
    logic [11:0] ADC0_40, ADC1_40, ADC2_40;
    logic [1:0]  ENABLE40;

    compat_fir_40mhz dut (
        .CLK120   (CLK120),
        .RESET_N  (RESET_N),
        .SYNC     (SYNC),
        .ADC0     (ADC0),
        .ADC1     (ADC1),
        .ADC2     (ADC2),
        .FILT0    (FILT0),
        .FILT1    (FILT1),
        .FILT2    (FILT2),
        .ADC0_40  (ADC0_40),
        .ADC1_40  (ADC1_40),
        .ADC2_40  (ADC2_40),
        .ENABLE40 (ENABLE40)
    );

    always #5 CLK120 = ~CLK120;

    // Full 21-tap impulse response and the impulse-test table (negatives clamp to 0).
    localparam int H   [21] = '{-2, 0, 6, 11, 0, -31, -48, 0, 129, 276, 342,
                                276, 129, 0, -48, -31, 0, 11, 6, 0, -2};
    localparam int IMP [21] = '{0, 0, 6, 11, 0, 0, 0, 0, 129, 276, 342,
                                276, 129, 0, 0, 0, 0, 11, 6, 0, 0};

    typedef struct { int due; int v0; int v1; int v2; } filt_exp_t;
    typedef struct { int due; int en; int a0; int a1; int a2; } ctl_exp_t;
    typedef struct { int due; int sig; int val; } dir_exp_t;

    filt_exp_t fq[$];
    ctl_exp_t  cq[$];
    dir_exp_t  dq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hist   [3][21];
    int ef     [3][1024];
    int en_m;
    int a40_m  [3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sigval(input int s);
        case (s)
            0: return int'(FILT0);
            1: return int'(FILT1);
            2: return int'(FILT2);
            3: return int'(ADC0_40);
            4: return int'(ADC1_40);
            5: return int'(ADC2_40);
            6: return int'(ENABLE40);
            default: return -1;
        endcase
    endfunction

    function automatic string signame(input int s);
        case (s)
            0: return "dir_filt0";
            1: return "dir_filt1";
            2: return "dir_filt2";
            3: return "dir_adc0_40";
            4: return "dir_adc1_40";
            5: return "dir_adc2_40";
            6: return "dir_enable40";
            default: return "dir_unknown";
        endcase
    endfunction

    task automatic push_dir(input int due, input int sig, input int val);
        dir_exp_t d;
        d.due = due; d.sig = sig; d.val = val;
        dq.push_back(d);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle.
    always @(negedge CLK120) begin
        if (RESET_N) begin
            while (fq.size() > 0 && fq[0].due <= cyc) begin
                if (fq[0].due < cyc) begin
                    chk("filt_due", cyc, fq[0].due);
                end else begin
                    chk("filt0", int'(FILT0), fq[0].v0);
                    chk("filt1", int'(FILT1), fq[0].v1);
                    chk("filt2", int'(FILT2), fq[0].v2);
                end
                void'(fq.pop_front());
            end
            while (cq.size() > 0 && cq[0].due <= cyc) begin
                if (cq[0].due < cyc) begin
                    chk("ctl_due", cyc, cq[0].due);
                end else begin
                    chk("enable40", int'(ENABLE40), cq[0].en);
                    chk("adc0_40", int'(ADC0_40), cq[0].a0);
                    chk("adc1_40", int'(ADC1_40), cq[0].a1);
                    chk("adc2_40", int'(ADC2_40), cq[0].a2);
                end
                void'(cq.pop_front());
            end
            for (int i = dq.size() - 1; i >= 0; i--) begin
                if (dq[i].due == cyc) begin
                    chk(signame(dq[i].sig), sigval(dq[i].sig), dq[i].val);
                    dq.delete(i);
                end
            end
        end
    end

    // Drive one cycle of input and push the model's expected responses.
    task automatic step(input int x0, input int x1, input int x2, input logic sync);
        int x [3];
        int acc;
        int y  [3];
        int en_n;
        filt_exp_t fe;
        ctl_exp_t  ce;
        x[0] = x0; x[1] = x1; x[2] = x2;
        ADC0 = x0[11:0]; ADC1 = x1[11:0]; ADC2 = x2[11:0];
        SYNC = sync;
        for (int c = 0; c < 3; c++) begin
            for (int j = 20; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = x[c];
            acc = 0;
            for (int j = 0; j < 21; j++) acc += H[j] * hist[c][j];
            y[c] = (acc + 512) >>> 10;
            if (y[c] < 0) y[c] = 0;
            if (y[c] > 4095) y[c] = 4095;
            ef[c][cyc + 6] = y[c];
        end
        fe.due = cyc + 6; fe.v0 = y[0]; fe.v1 = y[1]; fe.v2 = y[2];
        fq.push_back(fe);
        en_n = sync ? 0 : (en_m + 1) % 3;
        for (int c = 0; c < 3; c++) begin
            if (en_m == 2) a40_m[c] = ef[c][cyc];
        end
        ce.due = cyc + 1; ce.en = en_n;
        ce.a0 = a40_m[0]; ce.a1 = a40_m[1]; ce.a2 = a40_m[2];
        cq.push_back(ce);
        en_m = en_n;
        @(posedge CLK120);
        #1;
        cyc++;
    endtask

    // Asynchronous reset mid-cycle, immediate zero check, then release.
    task automatic do_reset();
        filt_exp_t fe;
        ctl_exp_t  ce;
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rst_filt0", int'(FILT0), 0);
        chk("rst_filt1", int'(FILT1), 0);
        chk("rst_filt2", int'(FILT2), 0);
        chk("rst_adc0_40", int'(ADC0_40), 0);
        chk("rst_adc1_40", int'(ADC1_40), 0);
        chk("rst_adc2_40", int'(ADC2_40), 0);
        chk("rst_enable40", int'(ENABLE40), 0);
        fq.delete(); cq.delete(); dq.delete();
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < 21; j++) hist[c][j] = 0;
            for (int j = 0; j < 1024; j++) ef[c][j] = 0;
            a40_m[c] = 0;
        end
        en_m = 0;
        ADC0 = 12'd0; ADC1 = 12'd0; ADC2 = 12'd0; SYNC = 1'b0;
        repeat (2) @(posedge CLK120);
        #1;
        RESET_N = 1'b1;
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            fe.due = k; fe.v0 = 0; fe.v1 = 0; fe.v2 = 0;
            fq.push_back(fe);
        end
        ce.due = 0; ce.en = 0; ce.a0 = 0; ce.a1 = 0; ce.a2 = 0;
        cq.push_back(ce);
        push_dir(0, 6, 0);
        push_dir(1, 6, 1);
        push_dir(2, 6, 2);
        push_dir(3, 6, 0);
    endtask

    initial begin
        int s;
        int held;
        logic synced;
        @(posedge CLK120);
        #1;

        // DC 1000 from reset.
        do_reset();
        push_dir(27, 0, 1000);
        push_dir(27, 1, 1000);
        push_dir(27, 2, 1000);
        push_dir(40, 3, 1000);
        push_dir(41, 4, 1000);
        for (int i = 0; i < 45; i++) step(1000, 1000, 1000, 1'b0);

        // Impulse of 1024 on channel 0 over a zero baseline.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1'b0);
        s = cyc;
        for (int k = 0; k < 21; k++) push_dir(s + 6 + k, 0, IMP[k]);
        push_dir(s + 16, 1, 0);
        push_dir(s + 16, 2, 0);
        step(1024, 0, 0, 1'b0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1'b0);

        // Overshoot above full scale clamps at 4095.
        s = cyc;
        push_dir(s + 18, 0, 4095);
        push_dir(s + 11, 0, 0);
        for (int i = 0; i < 30; i++) step(4095, 0, 0, 1'b0);
        // Undershoot below zero clamps at 0.
        s = cyc;
        push_dir(s + 18, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1'b0);

        // Ramp with one SYNC pulse landing in phase 1.
        do_reset();
        synced = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!synced && i >= 30 && en_m == 1) begin
                synced = 1'b1;
                held = a40_m[0];
                push_dir(cyc + 1, 6, 0);
                push_dir(cyc + 3, 3, held);
                step(200 + i, 300 + i, 400 + i, 1'b1);
            end else begin
                step(200 + i, 300 + i, 400 + i, 1'b0);
            end
        end
        SYNC = 1'b0;

        // Reset pulled during active data, then DC recovery.
        for (int i = 0; i < 30; i++) step(1000, 1000, 1000, 1'b0);
        do_reset();
        push_dir(27, 0, 1000);
        push_dir(27, 2, 1000);
        for (int i = 0; i < 45; i++) step(1000, 1000, 1000, 1'b0);

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK120);
            #1;
            cyc++;
        end
        chk("filt_queue_drained", fq.size(), 0);
        chk("ctl_queue_drained", cq.size(), 0);
        chk("dir_queue_drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
